// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// FSM encoding and default parameter values.
package hazard_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] MEM_TIMEOUT_DEF = 8'd200;
   localparam int         CNT_W_DEF       = 16;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   // Sticks at all-ones so a long run never wraps back to a small value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes,
// data-memory wait freeze with timeout, and hazard performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter logic [7:0] MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int         CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_jump,
   input  logic             ex_memread,
   input  logic [4:0]       ex_wreg,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             pipe_freeze,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       load_use;
   logic       timing_out;
   logic       stall;

   // Freeze has zero latency so the stage holding the access stops the same cycle
   always_comb begin
      load_use    = ex_memread && (ex_wreg != 5'd0) &&
                    ((ex_wreg == id_rs) || (ex_wreg == id_rt));
      timing_out  = (state == MEM_WAIT) && !mem_ready &&
                    (wait_cnt == (MEM_TIMEOUT - 8'd1));
      pipe_freeze = ((state == RUN) && mem_req && !mem_ready) ||
                    ((state == MEM_WAIT) && !mem_ready && !timing_out);
      stall       = load_use && !ex_branch_taken && !pipe_freeze;
      pc_stall    = stall;
      if_id_stall = stall;
      id_ex_stall = stall;
      id_ex_flush = ex_branch_taken && !pipe_freeze;
      if_id_flush = !pipe_freeze &&
                    (ex_branch_taken || (id_jump && !load_use));
      mem_timeout_err = timing_out;
   end

   // Memory-wait FSM; the wait counter restarts on every entry into MEM_WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready || timing_out) begin
                  state <= RUN;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (id_ex_stall),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_cnt)
   );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8'd200: maximum cycles to wait for mem_ready before abort.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 Reset is reset, asynchronous, active-high; clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_rs  in  5  rs field of the instruction in ID.
REQ-007 id_rt  in  5  rt field of the instruction in ID.
REQ-008 id_jump  in  1  j/jal/jr/jalr decoded in ID.
REQ-009 ex_memread  in  1  MemRead of the instruction in EX.
REQ-010 ex_wreg  in  5  destination register of the instruction in EX (after RegDst mux).
REQ-011 ex_branch_taken  in  1  branch in EX resolved taken.
REQ-012 mem_req  in  1  MEM stage issues a data-memory access this cycle.
REQ-013 mem_ready  in  1  data memory completes the access this cycle.
REQ-014 pc_stall  out  1  hold the PC.
REQ-015 if_id_stall  out  1  hold the IF/ID register.
REQ-016 if_id_flush  out  1  zero the IF/ID register.
REQ-017 id_ex_stall  out  1  load ID/EX with a bubble.
REQ-018 id_ex_flush  out  1  zero the ID/EX register.
REQ-019 pipe_freeze  out  1  clock-enable-low for all pipeline registers and the PC.
REQ-020 mem_timeout_err  out  1  one-cycle pulse on a memory-wait timeout.
REQ-021 stall_cnt  out  CNT_W  count of load-use bubble cycles.
REQ-022 flush_cnt  out  CNT_W  count of cycles with if_id_flush asserted.

Function
REQ-023 FSM states: RUN and MEM_WAIT.
REQ-024 RUN to MEM_WAIT when mem_req=1 and mem_ready=0.
REQ-025 MEM_WAIT to RUN when mem_ready=1, or when the wait counter equals MEM_TIMEOUT-1.
REQ-026 mem_ready=1 in the same cycle as mem_req: no state change and no freeze.
REQ-027 pipe_freeze is combinational: 1 when (state=RUN and mem_req and !mem_ready) or (state=MEM_WAIT and !mem_ready and not timing out); zero-cycle latency.
REQ-028 Wait counter: 8-bit; cleared on entering MEM_WAIT; +1 per MEM_WAIT cycle.
REQ-029 Timeout: on the cycle the counter equals MEM_TIMEOUT-1 with mem_ready=0, mem_timeout_err pulses high for 1 cycle, pipe_freeze drops, and the FSM returns to RUN.
REQ-030 Load-use: load_use = ex_memread and ex_wreg!=0 and (ex_wreg==id_rs or ex_wreg==id_rt).
REQ-031 When load_use=1, pc_stall, if_id_stall and id_ex_stall are all 1 in the same cycle; exactly one bubble is inserted per load.
REQ-032 When ex_branch_taken=1, if_id_flush and id_ex_flush are both 1.
REQ-033 Branch priority: ex_branch_taken=1 overrides load_use, forcing pc_stall, if_id_stall and id_ex_stall to 0.
REQ-034 Jump in ID: id_jump=1 with no taken branch drives if_id_flush=1, id_ex_flush=0.
REQ-035 id_jump=1 together with load_use=1: stall wins and if_id_flush=0; the jump re-evaluates next cycle.
REQ-036 pipe_freeze=1 forces all stall/flush outputs to 0 and suppresses counting; hazards are re-evaluated after the freeze.
REQ-037 stall_cnt increments on each edge where id_ex_stall=1; flush_cnt increments on each edge where if_id_flush=1.
REQ-038 Both counters saturate at all-ones.

Reset
REQ-039 Reset drives state=RUN, wait counter=0, mem_timeout_err=0, stall_cnt=0 and flush_cnt=0 immediately.
REQ-040 Combinational outputs follow their equations from state RUN while reset is held.
REQ-041 Reset asserted during MEM_WAIT aborts the wait with no error pulse.

Structure
REQ-042 FSM state encoding, MEM_TIMEOUT default and CNT_W default live in the shared pipeline package.
REQ-043 One sub-module, sat_counter (parameterised width, inc input), is used for both performance counters.

Verification
REQ-044 ex_memread=1, ex_wreg=8, id_rs=8 -> pc_stall, if_id_stall and id_ex_stall =1 for one cycle; stall_cnt 0->1.
REQ-045 Load-use stimulus plus ex_branch_taken=1 -> only if_id_flush and id_ex_flush =1; stall_cnt unchanged; flush_cnt +1.
REQ-046 mem_req=1 with mem_ready arriving 3 cycles later -> pipe_freeze=1 for exactly 3 cycles, then RUN.
REQ-047 MEM_TIMEOUT=4, mem_ready held 0 -> freeze for 4 cycles, mem_timeout_err pulses once on the 4th, then RUN.
REQ-048 stall_cnt preloaded to 16'hFFFE, three load-use events -> stall_cnt holds at 16'hFFFF.
REQ-049 Reset pulsed in MEM_WAIT -> state=RUN, pipe_freeze=0, counters 0, no mem_timeout_err.
